mux_readout_seq: RTL and testbench
==================================

MUX_READOUT_SEQ -- requirements
Module: mux_readout_seq

Interface
REQ-001 SHALL have parameter DW, default 32, mux data width.
REQ-002 SHALL have parameter NCH, default 16, number of mux channels; select width is 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request one readout pass.
REQ-006 SHALL have port chan_mask, input, NCH, channels to read; sampled only on an accepted start.
REQ-007 SHALL have port mux_q, input, DW, registered output of the 16:1 mux.
REQ-008 SHALL have port sel, output, 4, registered select driven to the mux S input.
REQ-009 SHALL have port out_data, output, DW, captured channel word.
REQ-010 SHALL have port out_chan, output, 4, channel index of out_data.
REQ-011 SHALL have port out_valid, output, 1, out_data/out_chan valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts word.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at end of pass.

Function
REQ-015 SHALL implement states IDLE, SETTLE, CAPTURE, PRESENT, DONE.
REQ-016 IDLE + start + nonzero chan_mask: SHALL latch mask into pend, set sel to lowest set bit, and go to SETTLE.
REQ-017 IDLE + start + zero chan_mask: SHALL go to DONE with no word emitted.
REQ-018 SETTLE SHALL last exactly one cycle (mux registers sel) and then go to CAPTURE.
REQ-019 At the CAPTURE-exit edge, SHALL latch mux_q into out_data and sel into out_chan, then go to PRESENT.
REQ-020 PRESENT SHALL hold out_valid=1 and keep out_data/out_chan stable until out_valid&&out_ready.
REQ-021 On the PRESENT handshake, SHALL clear pend[out_chan]; any remaining bit: set sel to the next lowest set bit and go to SETTLE; else go to DONE.
REQ-022 Start to first out_valid SHALL be 3 cycles; handshake to next out_valid SHALL be 3 cycles.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-024 start while busy SHALL be ignored; chan_mask changes mid-pass SHALL have no effect.
REQ-025 Channel order SHALL be ascending index; channel 15 SHALL be the last possible word; no wrap within a pass.
REQ-026 out_ready asserted outside PRESENT SHALL have no effect.

Reset
REQ-027 rst SHALL force IDLE, with sel=0, out_data=0, out_chan=0, out_valid=0, busy=0, done=0, pend=0.
REQ-028 rst in any state SHALL abort the pass with no done pulse; it takes priority over start and handshake in the same cycle.

Configuration
REQ-029 With MUX_SEQ_SKIP_ZERO_EN defined: a captured word equal to 0 SHALL NOT be presented; pend bit cleared, flow continues as if handshaked, with out_valid never asserted for it.
REQ-030 Without MUX_SEQ_SKIP_ZERO_EN: every masked channel SHALL be presented, including zero words.

Structure
REQ-031 State encoding typedef and the select-width constant (4) SHALL live in shared package mux_seq_pkg.
REQ-032 Lowest-set-bit priority encoder SHALL be sub-module prio_enc16 (16-bit in, 4-bit index plus any flag out), combinational.
REQ-033 The block SHALL instantiate alongside the existing 16x32 registered mux; it SHALL not contain a mux copy.

Verification
REQ-034 chan_mask=16'h0005, Dn=32'hA000_000n, out_ready=1: words A0000000 (chan 0) then A0000002 (chan 2); first valid 3 cycles after start; done one cycle after last handshake.
REQ-035 chan_mask=0: done pulses the cycle after start; out_valid never asserted.
REQ-036 chan_mask=16'h8001, out_ready held low 5 cycles: out_valid and out_data stable for those 5 cycles; chan 15 follows after release.
REQ-037 rst asserted during SETTLE of the second channel of mask 16'h00F0: all outputs 0 next cycle, no done; a new start then runs a clean pass.
REQ-038 Start re-pulsed mid-pass with a different mask: ignored; the original channel sequence completes.
REQ-039 MUX_SEQ_SKIP_ZERO_EN defined, mask 16'h0007, D1=0: only chans 0 and 2 presented, then done.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared state encoding and select width for the mux readout sequencer
package mux_seq_pkg;

    localparam int SEL_W  = 4;
    localparam int MUX_CH = 1 << SEL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/prio_enc16.sv
// rtl/prio_enc16.sv - lowest-set-bit priority encoder over the 16 mux channels
module prio_enc16
    import mux_seq_pkg::*;
(
    input  logic [MUX_CH-1:0] req,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = MUX_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_readout_seq.sv
// rtl/mux_readout_seq.sv - walks a channel mask through an external registered 16:1 mux
// Optional MUX_SEQ_SKIP_ZERO_EN: zero-valued captured words are dropped instead of presented.
module mux_readout_seq
    import mux_seq_pkg::*;
#(
    parameter int DW  = 32,
    parameter int NCH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH-1:0]   chan_mask,
    input  logic [DW-1:0]    mux_q,
    output logic [SEL_W-1:0] sel,
    output logic [DW-1:0]    out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    seq_state_t        state;
    logic [MUX_CH-1:0] pend;
    logic [MUX_CH-1:0] mask_ext;
    logic [MUX_CH-1:0] sel_onehot;
    logic [MUX_CH-1:0] pend_clr;
    logic [MUX_CH-1:0] enc_req;
    logic [SEL_W-1:0]  enc_idx;
    logic              enc_any;

    always_comb begin
        mask_ext = '0;
        mask_ext[NCH-1:0] = chan_mask;
    end

    // sel always equals the channel being worked on, so it names the bit to retire.
    assign sel_onehot = MUX_CH'(1) << sel;
    assign pend_clr   = pend & ~sel_onehot;
    assign enc_req    = (state == ST_IDLE) ? mask_ext : pend_clr;

    prio_enc16 u_prio_enc (
        .req (enc_req),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend      <= '0;
            sel       <= '0;
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (enc_any) begin
                            pend  <= mask_ext;
                            sel   <= enc_idx;
                            state <= ST_SETTLE;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
`ifdef MUX_SEQ_SKIP_ZERO_EN
                    if (mux_q == '0) begin
                        pend <= pend_clr;
                        if (enc_any) begin
                            sel   <= enc_idx;
                            state <= ST_SETTLE;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        out_data  <= mux_q;
                        out_chan  <= sel;
                        out_valid <= 1'b1;
                        state     <= ST_PRESENT;
                    end
`else
                    out_data  <= mux_q;
                    out_chan  <= sel;
                    out_valid <= 1'b1;
                    state     <= ST_PRESENT;
`endif
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pend      <= pend_clr;
                        if (enc_any) begin
                            sel   <= enc_idx;
                            state <= ST_SETTLE;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_readout_seq.sv
// tb/tb_mux_readout_seq.sv - directed bench for mux_readout_seq with a registered 16:1 mux model
module tb_mux_readout_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] chan_mask;
    logic [31:0] mux_q;
    logic [3:0]  sel;
    logic [31:0] out_data;
    logic [3:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [31:0] d [16];
    int          checks = 0;
    int          passes = 0;

    mux_readout_seq #(.DW(32), .NCH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chan_mask (chan_mask),
        .mux_q     (mux_q),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // External registered mux: one cycle from sel to mux_q.
    always @(posedge clk) mux_q <= d[sel];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_word(input string tag, input logic [3:0] ch, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
        chk({tag, "_data"}, out_data, data);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_chan"}, 32'(out_chan), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) d[i] = 32'hA000_0000 | i;
        rst = 1'b1; start = 1'b0; chan_mask = '0; out_ready = 1'b0;
        tick(); tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Mask 0x0005 with ready held high: chans 0 then 2.
        start = 1'b1; chan_mask = 16'h0005; out_ready = 1'b1;
        tick(); start = 1'b0;
        chk("t1_busy_settle", 32'(busy), 32'd1);
        chk("t1_valid_settle", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid_capture", 32'(out_valid), 32'd0);
        tick();
        chk_word("t1_w0", 4'd0, 32'hA000_0000);
        tick();
        chk("t1_valid_gap", 32'(out_valid), 32'd0);
        tick(); tick();
        chk_word("t1_w1", 4'd2, 32'hA000_0002);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd1);
        chk("t1_valid_done", 32'(out_valid), 32'd0);
        tick();
        chk("t1_done_clr", 32'(done), 32'd0);
        chk("t1_busy_clr", 32'(busy), 32'd0);

        // Empty mask: done the cycle after start, nothing presented.
        start = 1'b1; chan_mask = 16'h0000;
        tick(); start = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t2_done_clr", 32'(done), 32'd0);
        chk("t2_busy_clr", 32'(busy), 32'd0);
        chk("t2_valid_after", 32'(out_valid), 32'd0);

        // Mask 0x8001 with backpressure for 5 cycles on chan 0.
        out_ready = 1'b0;
        start = 1'b1; chan_mask = 16'h8001;
        tick(); start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk_word("t3_hold", 4'd0, 32'hA000_0000);
            tick();
        end
        chk_word("t3_hold_last", 4'd0, 32'hA000_0000);
        out_ready = 1'b1;
        tick();
        chk("t3_valid_drop", 32'(out_valid), 32'd0);
        tick(); tick();
        chk_word("t3_w15", 4'd15, 32'hA000_000F);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        tick();

        // Reset during SETTLE of the second channel of mask 0x00F0.
        start = 1'b1; chan_mask = 16'h00F0;
        tick(); start = 1'b0;
        tick(); tick();
        chk_word("t4_w4", 4'd4, 32'hA000_0004);
        tick();
        chk("t4_sel_settle", 32'(sel), 32'd5);
        rst = 1'b1;
        tick();
        chk_idle_outputs("t4_rst");
        rst = 1'b0;
        tick();
        chk("t4_no_done", 32'(done), 32'd0);
        chk("t4_no_busy", 32'(busy), 32'd0);
        start = 1'b1; chan_mask = 16'h0002;
        tick(); start = 1'b0;
        tick(); tick();
        chk_word("t4_clean", 4'd1, 32'hA000_0001);
        tick();
        chk("t4_clean_done", 32'(done), 32'd1);
        tick();

        // Start re-pulsed mid-pass with a different mask is ignored.
        start = 1'b1; chan_mask = 16'h0003;
        tick(); start = 1'b0;
        tick();
        start = 1'b1; chan_mask = 16'h0010;
        tick(); start = 1'b0;
        chk_word("t5_w0", 4'd0, 32'hA000_0000);
        tick(); tick(); tick();
        chk_word("t5_w1", 4'd1, 32'hA000_0001);
        tick();
        chk("t5_done", 32'(done), 32'd1);
        tick();
        chk("t5_idle", 32'(busy), 32'd0);

        // Zero-valued word on chan 1 of mask 0x0007.
        d[1] = 32'h0;
        start = 1'b1; chan_mask = 16'h0007;
        tick(); start = 1'b0;
        tick(); tick();
        chk_word("t6_w0", 4'd0, 32'hA000_0000);
`ifdef MUX_SEQ_SKIP_ZERO_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_skip_novalid", 32'(out_valid), 32'd0);
        end
        tick();
        chk_word("t6_w2", 4'd2, 32'hA000_0002);
`else
        tick(); tick(); tick();
        chk_word("t6_w1", 4'd1, 32'h0000_0000);
        tick(); tick(); tick();
        chk_word("t6_w2", 4'd2, 32'hA000_0002);
`endif
        tick();
        chk("t6_done", 32'(done), 32'd1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
